// File: rtl/sram_like_axi_pkg.sv
// sram_like_axi_pkg: shared state encoding, size codes and AXI constants for the sram-like to AXI bridge.
package sram_like_axi_pkg;

    typedef enum logic [2:0] {
        IDLE,
        RD_ADDR,
        RD_DATA,
        WR_REQ,
        WR_RESP
    } state_t;

    localparam logic [1:0] SZ_BYTE    = 2'd0;
    localparam logic [1:0] SZ_HALF    = 2'd1;
    localparam logic [1:0] SZ_WORD    = 2'd2;
    localparam logic [7:0] LEN_1      = 8'd0;
    localparam logic [1:0] BURST_INCR = 2'b01;

    // size code 3 is not legal on the sram-like side; it is folded onto word
    function automatic logic [1:0] norm_size(input logic [1:0] s);
        return (s == 2'd3) ? SZ_WORD : s;
    endfunction

endpackage

// File: rtl/sram_like_strb_gen.sv
// sram_like_strb_gen: byte-lane write strobes from access size and low address bits.
module sram_like_strb_gen
    import sram_like_axi_pkg::*;
(
    input  logic [1:0] size,
    input  logic [1:0] addr_lo,
    output logic [3:0] strb
);

    always_comb begin
        strb = (size == SZ_BYTE) ? (4'b0001 << addr_lo) :
               (size == SZ_HALF) ? (4'b0011 << {addr_lo[1], 1'b0}) :
                                   4'b1111;
    end

endmodule

// File: rtl/sram_like_axi_bridge.sv
// sram_like_axi_bridge: one sram-like master port to a single-beat, single-outstanding AXI master.
// Optional SRAM_LIKE_AXI_KSEG_MAP_EN folds kseg0/kseg1 addresses onto physical space at latch time.
module sram_like_axi_bridge
    import sram_like_axi_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req,
    input  logic              wr,
    input  logic [1:0]        size,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata,
    output logic              addr_ok,
    output logic              data_ok,
    output logic [ADDR_W-1:0] araddr,
    output logic [2:0]        arsize,
    output logic              arvalid,
    input  logic              arready,
    input  logic [DATA_W-1:0] r_data,
    input  logic              rvalid,
    output logic              rready,
    output logic [ADDR_W-1:0] awaddr,
    output logic [2:0]        awsize,
    output logic              awvalid,
    input  logic              awready,
    output logic [DATA_W-1:0] w_data,
    output logic [3:0]        wstrb,
    output logic              wvalid,
    input  logic              wready,
    input  logic              bvalid,
    output logic              bready
);

    state_t            state, state_nx;
    logic [1:0]        size_q;
    logic [ADDR_W-1:0] addr_q, addr_map;
    logic [DATA_W-1:0] wdata_q;
    logic              aw_done, w_done, hs, aw_ok, w_ok;

`ifdef SRAM_LIKE_AXI_KSEG_MAP_EN
    assign addr_map = (addr[ADDR_W-1 -: 2] == 2'b10) ? {3'b000, addr[ADDR_W-4:0]} : addr;
`else
    assign addr_map = addr;
`endif

    assign addr_ok = (state == IDLE) && !data_ok;
    assign hs      = req && addr_ok;
    assign aw_ok   = aw_done || awready;
    assign w_ok    = w_done || wready;

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE:    state_nx = hs ? (wr ? WR_REQ : RD_ADDR) : IDLE;
            RD_ADDR: state_nx = arready ? RD_DATA : RD_ADDR;
            RD_DATA: state_nx = rvalid ? IDLE : RD_DATA;
            WR_REQ:  state_nx = (aw_ok && w_ok) ? WR_RESP : WR_REQ;
            WR_RESP: state_nx = bvalid ? IDLE : WR_RESP;
            default: state_nx = IDLE;
        endcase
    end

    // AW and W complete independently; each flag remembers its own handshake until WR_REQ is left
    always_ff @(posedge clk) begin
        if (reset) begin
            data_ok <= 1'b0;
            rdata   <= '0;
            aw_done <= 1'b0;
            w_done  <= 1'b0;
            size_q  <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
        end else begin
            data_ok <= (state == RD_DATA && rvalid) || (state == WR_RESP && bvalid);
            aw_done <= (state == WR_REQ) && (state_nx == WR_REQ) && aw_ok;
            w_done  <= (state == WR_REQ) && (state_nx == WR_REQ) && w_ok;
            if (state == RD_DATA && rvalid) rdata <= r_data;
            if (hs) begin
                size_q  <= norm_size(size);
                addr_q  <= addr_map;
                wdata_q <= wdata;
            end
        end
    end

    assign arvalid = (state == RD_ADDR);
    assign rready  = (state == RD_DATA);
    assign awvalid = (state == WR_REQ) && !aw_done;
    assign wvalid  = (state == WR_REQ) && !w_done;
    assign bready  = (state == WR_RESP);
    assign araddr  = addr_q;
    assign awaddr  = addr_q;
    assign arsize  = {1'b0, size_q};
    assign awsize  = {1'b0, size_q};
    assign w_data  = wdata_q;

    sram_like_strb_gen u_strb (
        .size    (size_q),
        .addr_lo (addr_q[1:0]),
        .strb    (wstrb)
    );

endmodule

// File: tb/tb_sram_like_axi_bridge.sv
// tb_sram_like_axi_bridge: randomized self-checking bench with a reactive AXI slave and a transaction-level reference model.
module tb_sram_like_axi_bridge;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        req = 1'b0, wr = 1'b0;
    logic [1:0]  size = '0;
    logic [31:0] addr = '0, wdata = '0, rdata;
    logic        addr_ok, data_ok;
    logic [31:0] araddr, awaddr, w_data;
    logic [2:0]  arsize, awsize;
    logic        arvalid, arready = 1'b0, rvalid = 1'b0, rready;
    logic [31:0] r_data = '0;
    logic        awvalid, awready = 1'b0, wvalid, wready = 1'b0, bvalid = 1'b0, bready;
    logic [3:0]  wstrb;

    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    sram_like_axi_bridge #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk(clk), .reset(reset), .req(req), .wr(wr), .size(size), .addr(addr),
        .wdata(wdata), .rdata(rdata), .addr_ok(addr_ok), .data_ok(data_ok),
        .araddr(araddr), .arsize(arsize), .arvalid(arvalid), .arready(arready),
        .r_data(r_data), .rvalid(rvalid), .rready(rready),
        .awaddr(awaddr), .awsize(awsize), .awvalid(awvalid), .awready(awready),
        .w_data(w_data), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
        .bvalid(bvalid), .bready(bready)
    );

    function automatic logic [31:0] map_addr(input logic [31:0] a);
`ifdef SRAM_LIKE_AXI_KSEG_MAP_EN
        return (a[31:30] == 2'b10) ? {3'b000, a[28:0]} : a;
`else
        return a;
`endif
    endfunction

    // bytes covered = 1, 2 or 4, naturally aligned inside the word
    function automatic logic [3:0] exp_strb(input logic [1:0] s, input logic [1:0] a);
        int n = (s == 2'd0) ? 1 : (s == 2'd1) ? 2 : 4;
        int off = (int'(a) / n) * n;
        logic [3:0] m = 4'((1 << n) - 1);
        return m << off;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run_txn(input logic t_wr, input logic [1:0] t_size, input logic [31:0] t_addr,
                           input logic [31:0] t_wdata, input logic [31:0] t_rdata,
                           input int ar_d, input int r_d, input int aw_d, input int w_d, input int b_d,
                           input int exp_lat, input bit hold, input string nm);
        logic [31:0] ea = map_addr(t_addr);
        logic [2:0]  esz = {1'b0, (t_size == 2'd3) ? 2'd2 : t_size};
        logic [3:0]  es = exp_strb(t_size, t_addr[1:0]);
        int n = 0, c, resp_c = -1;
        int ar_hs = 0, r_hs = 0, aw_hs = 0, w_hs = 0, b_hs = 0;
        int ar_s = 0, r_s = 0, aw_s = 0, w_s = 0, b_s = 0;
        bit done = 0, rph, bph;
        req = 1'b1; wr = t_wr; size = t_size; addr = t_addr; wdata = t_wdata;
        while (addr_ok !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        total++;
        if (addr_ok !== 1'b1) begin
            bad++;
            $display("FAIL %s accept: addr_ok=%b required 1", nm, addr_ok);
        end
        tick();
        req = hold; wr = 1'($urandom); size = 2'($urandom); addr = $urandom; wdata = $urandom;
        for (c = 1; c < 100 && !done; c++) begin
            rph = !t_wr && ar_hs > 0 && r_hs == 0;
            bph = t_wr && aw_hs > 0 && w_hs > 0 && b_hs == 0;
            arready = 0; awready = 0; wready = 0; rvalid = 0; bvalid = 0; r_data = $urandom;
            total++;
            if (addr_ok !== 1'b0) begin
                bad++;
                $display("FAIL %s busy_addr_ok cyc=%0d: got %b required 0", nm, c, addr_ok);
            end
            if (data_ok === 1'b1) begin
                done = 1;
                total++;
                if (resp_c < 0 || c != resp_c + 1) begin
                    bad++;
                    $display("FAIL %s data_ok_timing: at cycle %0d required %0d", nm, c, resp_c + 1);
                end
                if (!t_wr) begin
                    total++;
                    if (rdata !== t_rdata) begin
                        bad++;
                        $display("FAIL %s rdata: got %h required %h", nm, rdata, t_rdata);
                    end
                end
                if (exp_lat >= 0) begin
                    total++;
                    if (c != exp_lat) begin
                        bad++;
                        $display("FAIL %s latency: got %0d required %0d", nm, c, exp_lat);
                    end
                end
            end else begin
                total++;
                if ({arvalid, rready, awvalid, wvalid, bready} !==
                    {!t_wr && ar_hs == 0, rph, t_wr && aw_hs == 0, t_wr && w_hs == 0, bph}) begin
                    bad++;
                    $display("FAIL %s handshake_lines cyc=%0d: ar/r/aw/w/b got %b%b%b%b%b required %b%b%b%b%b",
                             nm, c, arvalid, rready, awvalid, wvalid, bready,
                             !t_wr && ar_hs == 0, rph, t_wr && aw_hs == 0, t_wr && w_hs == 0, bph);
                end
                if (arvalid === 1'b1) begin
                    total++;
                    if ({araddr, arsize} !== {ea, esz}) begin
                        bad++;
                        $display("FAIL %s ar_chan: got %h/%0d required %h/%0d", nm, araddr, arsize, ea, esz);
                    end
                end
                if (awvalid === 1'b1) begin
                    total++;
                    if ({awaddr, awsize} !== {ea, esz}) begin
                        bad++;
                        $display("FAIL %s aw_chan: got %h/%0d required %h/%0d", nm, awaddr, awsize, ea, esz);
                    end
                end
                if (wvalid === 1'b1) begin
                    total++;
                    if ({w_data, wstrb} !== {t_wdata, es}) begin
                        bad++;
                        $display("FAIL %s w_chan: got %h/%b required %h/%b", nm, w_data, wstrb, t_wdata, es);
                    end
                end
                arready = (ar_s >= ar_d);
                awready = (aw_s >= aw_d);
                wready  = (w_s >= w_d);
                rvalid  = rph && r_s >= r_d;
                bvalid  = bph && b_s >= b_d;
                if (rvalid) r_data = t_rdata;
                if (arvalid && arready) ar_hs++;
                if (awvalid && awready) aw_hs++;
                if (wvalid && wready) w_hs++;
                if (rvalid && rready) begin r_hs++; resp_c = c; end
                if (bvalid && bready) begin b_hs++; resp_c = c; end
                ar_s += int'(arvalid); aw_s += int'(awvalid); w_s += int'(wvalid);
                r_s += int'(rph); b_s += int'(bph);
                tick();
            end
        end
        arready = 0; awready = 0; wready = 0; rvalid = 0; bvalid = 0;
        total++;
        if (!done) begin
            bad++;
            $display("FAIL %s timeout: no data_ok within %0d cycles", nm, c);
        end
        total++;
        if (t_wr ? (aw_hs != 1 || w_hs != 1 || b_hs != 1) : (ar_hs != 1 || r_hs != 1)) begin
            bad++;
            $display("FAIL %s hs_counts: ar=%0d r=%0d aw=%0d w=%0d b=%0d required one per channel",
                     nm, ar_hs, r_hs, aw_hs, w_hs, b_hs);
        end
        tick();
        total++;
        if ({data_ok, addr_ok} !== 2'b01) begin
            bad++;
            $display("FAIL %s post_pulse: data_ok/addr_ok got %b%b required 01", nm, data_ok, addr_ok);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) tick();
        total++;
        if ({arvalid, rready, awvalid, wvalid, bready, data_ok, addr_ok, rdata} !== {7'b0000001, 32'h0}) begin
            bad++;
            $display("FAIL reset_state: got %b%b%b%b%b%b%b rdata=%h required 0000001 rdata=0",
                     arvalid, rready, awvalid, wvalid, bready, data_ok, addr_ok, rdata);
        end
        reset = 1'b0;
        tick();
        total++;
        if ({arvalid, awvalid, wvalid, data_ok, addr_ok} !== 5'b00001) begin
            bad++;
            $display("FAIL reset_release: got %b%b%b%b%b required 00001", arvalid, awvalid, wvalid, data_ok, addr_ok);
        end
    endtask

    task automatic test_word_read();
        run_txn(1'b0, 2'd2, 32'h1FC0_0004, 32'h0, 32'hDEAD_BEEF, 0, 0, 0, 0, 0, 3, 1'b0, "word_read");
    endtask

    task automatic test_byte_write();
        run_txn(1'b1, 2'd0, 32'h0000_1003, 32'h1100_0000, 32'h0, 0, 0, 0, 0, 0, 3, 1'b0, "byte_write");
        run_txn(1'b1, 2'd1, 32'h0000_2002, 32'h5566_0000, 32'h0, 0, 0, 0, 0, 3, -1, 1'b0, "half_write");
    endtask

    task automatic test_write_order();
        run_txn(1'b1, 2'd2, 32'h0000_3000, 32'hA5A5_0001, 32'h0, 0, 0, 2, 0, 2, -1, 1'b0, "w_before_aw");
        run_txn(1'b1, 2'd2, 32'h0000_3004, 32'hA5A5_0002, 32'h0, 0, 0, 0, 2, 1, -1, 1'b0, "aw_before_w");
        run_txn(1'b1, 2'd3, 32'h0000_3008, 32'hA5A5_0003, 32'h0, 0, 0, 1, 1, 0, -1, 1'b0, "aw_w_same");
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 4; i++)
            run_txn(1'b0, 2'd2, 32'h0000_4000 + 32'(i * 4), 32'h0, 32'hC0DE_0000 + 32'(i),
                    0, 5, 0, 0, 0, -1, i < 3, "back_to_back");
        req = 1'b0;
    endtask

    task automatic test_reset_mid();
        req = 1'b1; wr = 1'b0; size = 2'd2; addr = 32'h0000_5000;
        tick();
        req = 1'b0; arready = 1'b1;
        tick();
        arready = 1'b0;
        total++;
        if (rready !== 1'b1) begin
            bad++;
            $display("FAIL reset_mid_setup: rready got %b required 1", rready);
        end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        total++;
        if ({arvalid, rready, data_ok, addr_ok} !== 4'b0001) begin
            bad++;
            $display("FAIL reset_mid: ar/r/data_ok/addr_ok got %b%b%b%b required 0001", arvalid, rready, data_ok, addr_ok);
        end
        tick();
    endtask

    task automatic test_kseg();
        run_txn(1'b0, 2'd2, 32'hBFC0_0000, 32'h0, 32'h1234_5678, 0, 0, 0, 0, 0, 3, 1'b0, "kseg_read");
        run_txn(1'b1, 2'd2, 32'h8000_0010, 32'h8765_4321, 32'h0, 1, 0, 0, 0, 0, -1, 1'b0, "kseg_write");
    endtask

    task automatic test_random();
        for (int i = 0; i < 40; i++) begin
            logic [31:0] a = $urandom;
            if ($urandom_range(0, 2) == 0) a[31:30] = 2'b10;
            run_txn(1'($urandom), 2'($urandom), a, $urandom, $urandom,
                    $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
                    $urandom_range(0, 3), $urandom_range(0, 3), -1, 1'($urandom), "random");
        end
        req = 1'b0;
        tick();
    endtask

    initial begin
        test_reset();
        test_word_read();
        test_byte_write();
        test_write_order();
        test_back_to_back();
        test_reset_mid();
        test_kseg();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/sram_like_axi_bridge.md
Name: sram_like_axi_bridge

Overview:
- Converts one sram-like master port into a single-beat AXI master. Instantiated once for the inst port and once for the data port of cpu_sram_like.
- An external AXI crossbar merges the two bridges.
- Allows one outstanding transaction, read or write. Every burst has length 1 (arlen/awlen=0, INCR), so AXI ID, len, burst, lock, cache and prot are constants driven at top level and are not ported.

Parameters:
ADDR_W, 32, address width (sram-like and AXI)
DATA_W, 32, data width; only 32 is supported

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
req  in  1  sram-like request
wr  in  1  1=write, 0=read
size  in  2  0=byte, 1=half, 2=word
addr  in  ADDR_W  byte address
wdata  in  DATA_W  write data
rdata  out  DATA_W  read data, valid with data_ok
addr_ok  out  1  request accepted this cycle
data_ok  out  1  one-cycle completion pulse
araddr  out  ADDR_W  AXI read address
arsize  out  3  AXI read size
arvalid  out  1  AR valid
arready  in  1  AR ready
r_data  in  DATA_W  AXI read data
rvalid  in  1  R valid
rready  out  1  R ready
awaddr  out  ADDR_W  AXI write address
awsize  out  3  AXI write size
awvalid  out  1  AW valid
awready  in  1  AW ready
w_data  out  DATA_W  AXI write data
wstrb  out  4  write strobes
wvalid  out  1  W valid
wready  in  1  W ready
bvalid  in  1  B valid
bready  out  1  B ready

Behaviour:
- FSM states: IDLE, RD_ADDR, RD_DATA, WR_REQ, WR_RESP. Reset and flush both land in IDLE.
- Reset values: state=IDLE; all valid and ready outputs 0; data_ok=0; rdata=0.
- addr_ok = (state==IDLE) and no data_ok pending. Handshake occurs on the cycle where req && addr_ok.
- On handshake, latch wr, size, addr and wdata. Go to RD_ADDR if wr=0, else WR_REQ.
- RD_ADDR:
  - arvalid=1 from the cycle after the handshake.
  - araddr and arsize hold stable until arready.
  - On arready, go to RD_DATA.
- RD_DATA:
  - rready=1.
  - On rvalid, register r_data into rdata, pulse data_ok on the next cycle, and return to IDLE.
- WR_REQ:
  - awvalid and wvalid rise together.
  - Each drops independently on its own ready.
  - awready and wready may arrive in either order or in the same cycle.
  - Go to WR_RESP once both handshakes are done.
- WR_RESP:
  - bready=1.
  - On bvalid, pulse data_ok on the next cycle and return to IDLE.
  - bresp is ignored.
- Minimum latency: read = handshake + 1 (AR) + 1 (R) + 1 (data_ok). Write = handshake + 1 (AW/W) + 1 (B) + 1.
- addr_ok stays low during the data_ok cycle, so a back-to-back request is accepted one cycle later.
- arsize/awsize = {1'b0, size}. size=3 is illegal and is treated as 2 (word).
- wstrb:
  - size0: 4'b0001<<addr[1:0]
  - size1: 4'b0011<<{addr[1],1'b0}
  - size2: 4'b1111
- w_data = latched wdata unmodified; the CPU already replicates lanes.
- req while busy is ignored (addr_ok=0). The master must hold req until addr_ok.
- Reset mid-transaction abandons it; all outputs return to reset values the next cycle. The system contract requires the slave to be reset together with the bridge.

Optional Feature:
SRAM_LIKE_AXI_KSEG_MAP_EN
- Defined: for addr[31:30]==2'b10 (kseg0/kseg1), araddr/awaddr = {3'b000, addr[28:0]}. All other addresses pass through unchanged. The mapping is applied at latch time, with no extra latency.
- Undefined: addresses pass through untranslated.

Decomposition:
- Package sram_like_axi_pkg: FSM state enum; size encodings (SZ_BYTE=0, SZ_HALF=1, SZ_WORD=2); AXI constants (LEN_1=0, BURST_INCR=2'b01).
- Sub-module sram_like_strb_gen: combinational size+addr[1:0] -> wstrb. It is reused by the data path.

Test Plan:
- Word read addr=0x1FC0_0004, arready and rvalid immediate, r_data=0xDEAD_BEEF -> arsize=2; data_ok pulses 3 cycles after the handshake with rdata=0xDEAD_BEEF.
- Byte write addr=0x...0003, wdata=0x1100_0000, size=0 -> wstrb=4'b1000, awsize=0; data_ok pulses 1 cycle after bvalid.
- Write with wready 2 cycles before awready, then the reverse order, then both in the same cycle -> exactly one AW and one W handshake each; data_ok fires only after bvalid.
- req held high continuously for 4 reads with 5-cycle rvalid delay -> addr_ok rises only in IDLE; exactly 4 data_ok pulses, in order.
- Reset asserted during RD_DATA -> next cycle: arvalid=0, rready=0, data_ok=0, addr_ok=1.
- With SRAM_LIKE_AXI_KSEG_MAP_EN, read 0xBFC0_0000 -> araddr=0x1FC0_0000. Without it -> araddr=0xBFC0_0000.
